// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic ranging blocks: measurement FSM
// states, default timing constants and counter widths.
package sonic_pkg;

   localparam int unsigned US_PER_CM_DEF  = 58;
   localparam int unsigned TIMEOUT_US_DEF = 30000;
   localparam int unsigned US_CNT_W       = 15;
   localparam int unsigned CM_CNT_W       = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_DONE
   } meas_state_t;

endpackage

// File: rtl/echo_sync.sv
// Multi-flop synchronizer for the asynchronous echo line, followed by a
// single edge-detect flop producing one-clk rise/fall pulses.
module echo_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   always_comb begin
      level = sync_q[SYNC_STAGES-1];
      rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
      fall  = ~sync_q[SYNC_STAGES-1] & prev_q;
   end

endmodule

// File: rtl/echo_measure.sv
// Echo pulse-width to distance converter: counts microsecond ticks while the
// synchronized echo is high and converts to centimetres by repeated wrap.
module echo_measure
   import sonic_pkg::*;
#(
   parameter int unsigned US_PER_CM   = US_PER_CM_DEF,
   parameter int unsigned TIMEOUT_US  = TIMEOUT_US_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       us_tick,
   input  logic       trig_done,
   input  logic       echo,
   output logic       busy,
   output logic [9:0] dist_cm,
   output logic       dist_valid,
   output logic       timeout
);

   localparam int unsigned SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
   localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(US_PER_CM - 1);
   localparam logic [US_CNT_W-1:0] US_LAST  = US_CNT_W'(TIMEOUT_US - 1);

   meas_state_t         state_q, state_d;
   logic [US_CNT_W-1:0] us_q, us_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [CM_CNT_W-1:0] cm_q, cm_d;
   logic [9:0]          dist_q, dist_d;
   logic                timeout_q, timeout_d;

   logic echo_level, echo_rise, echo_fall;

   echo_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (echo),
      .level (echo_level),
      .rise  (echo_rise),
      .fall  (echo_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         us_q      <= '0;
         sub_q     <= '0;
         cm_q      <= '0;
         dist_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         us_q      <= us_d;
         sub_q     <= sub_d;
         cm_q      <= cm_d;
         dist_q    <= dist_d;
         timeout_q <= timeout_d;
      end
   end

   // dist is captured on the MEASURE->DONE edge so it is already valid
   // during the single DONE cycle that raises dist_valid.
   always_comb begin
      state_d   = state_q;
      us_d      = us_q;
      sub_d     = sub_q;
      cm_d      = cm_q;
      dist_d    = dist_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig_done) begin
               state_d = ST_WAIT_RISE;
               us_d    = '0;
               sub_d   = '0;
               cm_d    = '0;
            end
         end
         ST_WAIT_RISE: begin
            if (echo_rise) begin
               state_d = ST_MEASURE;
               us_d    = '0;
            end else if (us_tick) begin
               if (us_q == US_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  us_d = us_q + 1'b1;
               end
            end
         end
         ST_MEASURE: begin
            if (echo_fall) begin
               state_d = ST_DONE;
               dist_d  = cm_q;
            end else if (us_tick && echo_level) begin
               if (us_q == US_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  us_d = us_q + 1'b1;
                  if (sub_q == SUB_LAST) begin
                     sub_d = '0;
                     cm_d  = cm_q + 1'b1;
                  end else begin
                     sub_d = sub_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      dist_valid = (state_q == ST_DONE);
      dist_cm    = dist_q;
      timeout    = timeout_q;
   end

endmodule
